// File: rtl/noc_xbar_router.sv
`default_nettype none
// ============================================================================
// Module   : noc_xbar_router
// Purpose  : 5-port mesh NoC router (NI, N, S, E, W). Each input has a FIFO,
//            heads are XY-routed, each output has a round-robin arbiter that
//            loads a registered valid/ready output stage.
//            Optional build macro ROUTER_STATS_EN: saturating per-output
//            delivered-packet counters on o_stats (tied to 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module noc_xbar_router #(
    parameter int GRID_ROWS          = 4,
    parameter int GRID_COLS          = 4,
    parameter int PACKET_WIDTH       = 8,
    parameter int ROW_LSB            = 2,
    parameter int COL_LSB            = 0,
    parameter int FIFO_ADDRESS_WIDTH = 2,
    parameter int ROUTER_ROW         = 0,
    parameter int ROUTER_COL         = 0,
    parameter int STATS_W            = 16
) (
    input  logic                         i_clk,
    input  logic                         i_arst_n,
    input  logic [4:0][PACKET_WIDTH-1:0] i_inData,
    input  logic [4:0]                   i_inValid,
    output logic [4:0]                   o_inReady,
    output logic [4:0][PACKET_WIDTH-1:0] o_outData,
    output logic [4:0]                   o_outValid,
    input  logic [4:0]                   i_outReady,
    output logic [4:0]                   o_drop,
    output logic [4:0][STATS_W-1:0]      o_stats
);

    localparam int c_ROW_W = $clog2(GRID_ROWS);
    localparam int c_COL_W = $clog2(GRID_COLS);
    localparam int c_AW    = FIFO_ADDRESS_WIDTH;
    localparam int c_DEPTH = 2 ** FIFO_ADDRESS_WIDTH;

    localparam logic [c_ROW_W-1:0] c_MY_ROW = c_ROW_W'(ROUTER_ROW);
    localparam logic [c_COL_W-1:0] c_MY_COL = c_COL_W'(ROUTER_COL);

    localparam logic [2:0] c_P_NI = 3'd0;
    localparam logic [2:0] c_P_N  = 3'd1;
    localparam logic [2:0] c_P_S  = 3'd2;
    localparam logic [2:0] c_P_E  = 3'd3;
    localparam logic [2:0] c_P_W  = 3'd4;

    // Bit p set when output port p physically exists at this mesh position.
    localparam logic [4:0] c_PORT_EXISTS = {
        (ROUTER_COL != 0),
        (ROUTER_COL != GRID_COLS - 1),
        (ROUTER_ROW != GRID_ROWS - 1),
        (ROUTER_ROW != 0),
        1'b1
    };

    // Index (base + off) modulo 5, for base in 0..4 and off in 0..4.
    function automatic logic [2:0] f_wrap(input logic [2:0] base, input int unsigned off);
        logic [3:0] s;
        s = {1'b0, base} + 4'(off);
        if (s >= 4'd5) begin
            s = s - 4'd5;
        end
        return s[2:0];
    endfunction

    // Input FIFO storage and pointers. The extra pointer bit separates full from empty.
    logic [PACKET_WIDTH-1:0]      r_mem [5][c_DEPTH];
    logic [4:0][c_AW:0]           r_wr_ptr;
    logic [4:0][c_AW:0]           r_wr_vis;  // write pointer as seen by the read side, one cycle late
    logic [4:0][c_AW:0]           r_rd_ptr;

    logic [4:0]                   w_full;
    logic [4:0]                   w_head_vld;
    logic [4:0]                   w_wr;
    logic [4:0]                   w_pop;
    logic [4:0]                   w_drop;
    logic [4:0][PACKET_WIDTH-1:0] w_head;
    logic [4:0][c_ROW_W-1:0]      w_dst_row;
    logic [4:0][c_COL_W-1:0]      w_dst_col;
    logic [4:0][2:0]              w_route;
    logic [4:0][4:0]              w_req;      // [output][input]
    logic [4:0]                   w_can_load;
    logic [4:0]                   w_gnt_vld;
    logic [4:0][2:0]              w_gnt_idx;

    logic [4:0][2:0]              r_ptr;
    logic [4:0]                   r_out_valid;
    logic [4:0][PACKET_WIDTH-1:0] r_out_data;
    logic [4:0]                   r_drop;

    // FIFO status and head-of-line packet per input.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_full[i]     = (r_wr_ptr[i][c_AW] != r_rd_ptr[i][c_AW]) &&
                            (r_wr_ptr[i][c_AW-1:0] == r_rd_ptr[i][c_AW-1:0]);
            w_head_vld[i] = (r_rd_ptr[i] != r_wr_vis[i]);
            w_head[i]     = r_mem[i][r_rd_ptr[i][c_AW-1:0]];
            w_wr[i]       = i_inValid[i] && !w_full[i];
        end
    end

    // XY route of each head; heads aimed at a missing port become drops, others requests.
    always_comb begin
        w_dst_row = '0;
        w_dst_col = '0;
        w_route   = '0;
        w_drop    = '0;
        w_req     = '0;
        for (int i = 0; i < 5; i++) begin
            w_dst_row[i] = w_head[i][ROW_LSB +: c_ROW_W];
            w_dst_col[i] = w_head[i][COL_LSB +: c_COL_W];
            if (w_dst_col[i] > c_MY_COL) begin
                w_route[i] = c_P_E;
            end else if (w_dst_col[i] < c_MY_COL) begin
                w_route[i] = c_P_W;
            end else if (w_dst_row[i] > c_MY_ROW) begin
                w_route[i] = c_P_S;
            end else if (w_dst_row[i] < c_MY_ROW) begin
                w_route[i] = c_P_N;
            end else begin
                w_route[i] = c_P_NI;
            end
            w_drop[i] = w_head_vld[i] && !c_PORT_EXISTS[w_route[i]];
            for (int o = 0; o < 5; o++) begin
                w_req[o][i] = w_head_vld[i] && (w_route[i] == 3'(o)) && c_PORT_EXISTS[o];
            end
        end
    end

    // Round-robin arbiter per output; a grant is only issued when the output stage can load.
    always_comb begin
        w_can_load = '0;
        w_gnt_vld  = '0;
        w_gnt_idx  = r_ptr;
        for (int o = 0; o < 5; o++) begin
            w_can_load[o] = !r_out_valid[o] || i_outReady[o];
            for (int k = 0; k < 5; k++) begin
                if (w_can_load[o] && !w_gnt_vld[o] && w_req[o][f_wrap(r_ptr[o], k)]) begin
                    w_gnt_vld[o] = 1'b1;
                    w_gnt_idx[o] = f_wrap(r_ptr[o], k);
                end
            end
        end
    end

    // An input pops when its head wins an output or is dropped.
    always_comb begin
        w_pop = w_drop;
        for (int o = 0; o < 5; o++) begin
            if (w_gnt_vld[o]) begin
                w_pop[w_gnt_idx[o]] = 1'b1;
            end
        end
    end

    // FIFO storage write; contents need no reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 5; i++) begin
            if (w_wr[i]) begin
                r_mem[i][r_wr_ptr[i][c_AW-1:0]] <= i_inData[i];
            end
        end
    end

    // FIFO pointer update; a write becomes readable one cycle after it lands.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_wr_ptr <= '0;
            r_wr_vis <= '0;
            r_rd_ptr <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (w_wr[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                end
                r_wr_vis[i] <= r_wr_ptr[i];
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                end
            end
        end
    end

    // Output registers and arbiter pointers; data is cleared whenever valid drops.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_out_valid <= '0;
            r_out_data  <= '0;
            r_ptr       <= '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (w_gnt_vld[o]) begin
                    r_out_valid[o] <= 1'b1;
                    r_out_data[o]  <= w_head[w_gnt_idx[o]];
                    r_ptr[o]       <= f_wrap(w_gnt_idx[o], 1);
                end else if (r_out_valid[o] && i_outReady[o]) begin
                    r_out_valid[o] <= 1'b0;
                    r_out_data[o]  <= '0;
                end
            end
        end
    end

    // One-cycle drop indication for each unroutable head that was discarded.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_drop <= '0;
        end else begin
            r_drop <= w_drop;
        end
    end

    assign o_inReady  = ~w_full;
    assign o_outValid = r_out_valid & c_PORT_EXISTS;
    assign o_outData  = r_out_data;
    assign o_drop     = r_drop;

`ifdef ROUTER_STATS_EN
    logic [4:0][STATS_W-1:0] r_stats;

    // Saturating count of completed output handshakes per port.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_stats <= '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (o_outValid[o] && i_outReady[o] && (r_stats[o] != {STATS_W{1'b1}})) begin
                    r_stats[o] <= r_stats[o] + 1'b1;
                end
            end
        end
    end

    assign o_stats = r_stats;
`else
    assign o_stats = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_xbar_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_xbar_router
// Purpose  : Self-checking bench for noc_xbar_router. Three routers: (1,1) and
//            (0,3) on a 4x4 grid, and (1,2) on a 4x3 grid with STATS_W=2.
//            Per-output scoreboards check ordering and content of delivered packets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_xbar_router;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0][7:0]  in_data   [3];
    logic [4:0]       in_valid  [3];
    logic [4:0]       in_ready  [3];
    logic [4:0][7:0]  out_data  [3];
    logic [4:0]       out_valid [3];
    logic [4:0]       out_ready [3];
    logic [4:0]       drop      [3];
    logic [4:0][15:0] stats_a;
    logic [4:0][15:0] stats_b;
    logic [4:0][1:0]  stats_c;

    logic [7:0] exp_q [15][$];
    int checks = 0;
    int errors = 0;

`ifdef ROUTER_STATS_EN
    localparam logic [15:0] EXP_STATS_A = 16'd3;
    localparam logic [1:0]  EXP_STATS_C = 2'd3;
`else
    localparam logic [15:0] EXP_STATS_A = 16'd0;
    localparam logic [1:0]  EXP_STATS_C = 2'd0;
`endif

    noc_xbar_router #(.GRID_ROWS(4), .GRID_COLS(4), .ROUTER_ROW(1), .ROUTER_COL(1)) u_a (
        .i_clk(clk), .i_arst_n(arst_n), .i_inData(in_data[0]), .i_inValid(in_valid[0]),
        .o_inReady(in_ready[0]), .o_outData(out_data[0]), .o_outValid(out_valid[0]),
        .i_outReady(out_ready[0]), .o_drop(drop[0]), .o_stats(stats_a));

    noc_xbar_router #(.GRID_ROWS(4), .GRID_COLS(4), .ROUTER_ROW(0), .ROUTER_COL(3)) u_b (
        .i_clk(clk), .i_arst_n(arst_n), .i_inData(in_data[1]), .i_inValid(in_valid[1]),
        .o_inReady(in_ready[1]), .o_outData(out_data[1]), .o_outValid(out_valid[1]),
        .i_outReady(out_ready[1]), .o_drop(drop[1]), .o_stats(stats_b));

    noc_xbar_router #(.GRID_ROWS(4), .GRID_COLS(3), .ROUTER_ROW(1), .ROUTER_COL(2),
                      .STATS_W(2)) u_c (
        .i_clk(clk), .i_arst_n(arst_n), .i_inData(in_data[2]), .i_inValid(in_valid[2]),
        .o_inReady(in_ready[2]), .o_outData(out_data[2]), .o_outValid(out_valid[2]),
        .i_outReady(out_ready[2]), .o_drop(drop[2]), .o_stats(stats_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each output handshake pops and compares; idle outputs must show zero data.
    always @(negedge clk) begin
        if (arst_n) begin
            for (int d = 0; d < 3; d++) begin
                for (int o = 0; o < 5; o++) begin
                    if (out_valid[d][o] && out_ready[d][o]) begin
                        if (exp_q[d*5+o].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out inst=%0d port=%0d actual=%0h required=none",
                                     d, o, out_data[d][o]);
                        end else begin
                            chk($sformatf("sb_data inst=%0d port=%0d", d, o),
                                out_data[d][o], exp_q[d*5+o].pop_front());
                        end
                    end else if (!out_valid[d][o]) begin
                        chk($sformatf("idle_zero inst=%0d port=%0d", d, o), out_data[d][o], 0);
                    end
                end
            end
            chk("edge_ports_b", {out_valid[1][3], out_valid[1][1]}, 0);
            chk("edge_port_c", out_valid[2][3], 0);
        end
    end

    function automatic bit idle();
        for (int q = 0; q < 15; q++) begin
            if (exp_q[q].size() != 0) return 1'b0;
        end
        for (int d = 0; d < 3; d++) begin
            if (out_valid[d] != 5'b0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!idle() && n < 60) begin
            step();
            n++;
        end
        chk({"drain_", name}, idle(), 1);
    endtask

    // One-cycle injection; op < 0 means the packet is not expected anywhere.
    task automatic send(input int d, input int p, input logic [7:0] data, input int op);
        in_data[d][p]  = data;
        in_valid[d][p] = 1'b1;
        chk($sformatf("in_ready inst=%0d port=%0d", d, p), in_ready[d][p], 1);
        if (op >= 0) exp_q[d*5+op].push_back(data);
        step();
        in_valid[d][p] = 1'b0;
    endtask

    typedef struct {
        int         src;
        logic [7:0] data;
        int         dst;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int nxt;
        int hold_bad;
        int cnt;
        int drop_at;
        int other;
        bit acc;
        logic [7:0] pkts [8];

        vecs[0]  = '{0, 8'h07, 3};
        vecs[1]  = '{0, 8'h01, 1};
        vecs[2]  = '{0, 8'h0D, 2};
        vecs[3]  = '{0, 8'h04, 4};
        vecs[4]  = '{1, 8'h05, 0};
        vecs[5]  = '{2, 8'hAA, 3};
        vecs[6]  = '{3, 8'h30, 4};
        vecs[7]  = '{4, 8'h5F, 3};
        vecs[8]  = '{3, 8'h61, 1};
        vecs[9]  = '{4, 8'h29, 2};
        vecs[10] = '{1, 8'hE5, 0};
        for (int k = 0; k < 8; k++) pkts[k] = 8'((k << 4) | 8'h07);

        for (int d = 0; d < 3; d++) begin
            in_data[d]   = '0;
            in_valid[d]  = '0;
            out_ready[d] = 5'h1F;
        end

        // Reset state.
        step();
        step();
        arst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid inst=%0d", d), out_valid[d], 0);
            chk($sformatf("rst_data inst=%0d", d), out_data[d], 0);
            chk($sformatf("rst_inready inst=%0d", d), in_ready[d], 5'h1F);
            chk($sformatf("rst_drop inst=%0d", d), drop[d], 0);
        end
        chk("rst_stats_a", stats_a, 0);
        chk("rst_stats_c", stats_c, 0);

        // Latency: NI injects 07 at router (1,1), E output valid only after the second edge.
        send(0, 0, 8'h07, 3);
        chk("lat_edge0", out_valid[0], 0);
        step();
        chk("lat_edge1", out_valid[0], 0);
        step();
        chk("lat_edge2_valid", out_valid[0], 5'b01000);
        chk("lat_edge2_data", out_data[0][3], 8'h07);
        drain("lat");

        // Round-robin on NI output: ptr=0 serves N then S.
        in_data[0][1] = 8'h15;
        in_data[0][2] = 8'h25;
        in_valid[0][2:1] = 2'b11;
        exp_q[0].push_back(8'h15);
        exp_q[0].push_back(8'h25);
        step();
        in_valid[0][2:1] = 2'b00;
        step();
        step();
        chk("rr0_first", out_data[0][0], 8'h15);
        step();
        chk("rr0_second", out_data[0][0], 8'h25);
        drain("rr0");
        // A lone grant to N leaves ptr=2, so S wins the next tie.
        send(0, 1, 8'h35, 0);
        drain("rr1");
        in_data[0][1] = 8'h45;
        in_data[0][2] = 8'h55;
        in_valid[0][2:1] = 2'b11;
        exp_q[0].push_back(8'h55);
        exp_q[0].push_back(8'h45);
        step();
        in_valid[0][2:1] = 2'b00;
        step();
        step();
        chk("rr2_first", out_data[0][0], 8'h55);
        step();
        chk("rr2_second", out_data[0][0], 8'h45);
        drain("rr2");

        // Routing table at router (1,1).
        for (int i = 0; i < 11; i++) begin
            send(0, vecs[i].src, vecs[i].data, vecs[i].dst);
            drain($sformatf("vec%0d", i));
        end

        // Backpressure: E stalled, W streams 8 packets; 5 fit (4 FIFO + output register).
        out_ready[0][3] = 1'b0;
        nxt = 0;
        hold_bad = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid[0][4] = (nxt < 8);
            in_data[0][4]  = pkts[nxt % 8];
            acc = in_ready[0][4];
            step();
            if (acc && nxt < 8) begin
                exp_q[3].push_back(pkts[nxt]);
                nxt++;
            end
            if (c >= 2 && !(out_valid[0][3] && out_data[0][3] == 8'h07)) hold_bad++;
        end
        chk("bp_accepted", nxt, 5);
        chk("bp_inready_low", in_ready[0][4], 0);
        chk("bp_hold", hold_bad, 0);
        out_ready[0][3] = 1'b1;
        for (int c = 0; c < 30 && nxt < 8; c++) begin
            in_valid[0][4] = 1'b1;
            in_data[0][4]  = pkts[nxt];
            acc = in_ready[0][4];
            step();
            if (acc) begin
                exp_q[3].push_back(pkts[nxt]);
                nxt++;
            end
        end
        in_valid[0][4] = 1'b0;
        chk("bp_all_accepted", nxt, 8);
        drain("bp");

        // Four distinct outputs in parallel.
        in_data[0][0] = 8'h07;
        in_data[0][1] = 8'h09;
        in_data[0][2] = 8'h01;
        in_data[0][3] = 8'h04;
        in_valid[0] = 5'b01111;
        exp_q[3].push_back(8'h07);
        exp_q[2].push_back(8'h09);
        exp_q[1].push_back(8'h01);
        exp_q[4].push_back(8'h04);
        step();
        in_valid[0] = 5'b0;
        step();
        step();
        chk("par_valid", out_valid[0], 5'b11110);
        drain("par");

        // Router (0,3): local delivery, westbound, southbound; N and E never valid.
        send(1, 0, 8'h03, 0);
        send(1, 3, 8'h00, 4);
        send(1, 2, 8'h0F, 2);
        send(1, 3, 8'h02, 4);
        drain("b");

        // Router (1,2) on 4x3 grid: column 3 is off-grid east, so it is dropped.
        send(2, 0, 8'h07, -1);
        cnt = 0;
        drop_at = -1;
        other = 0;
        for (int c = 0; c < 6; c++) begin
            if (drop[2][0]) begin
                cnt++;
                drop_at = c;
            end
            if (drop[2][4:1] != 4'b0 || drop[0] != 5'b0 || drop[1] != 5'b0) other++;
            step();
        end
        chk("drop_pulses", cnt, 1);
        chk("drop_time", drop_at, 2);
        chk("drop_other", other, 0);
        chk("drop_fifo_empty", in_ready[2], 5'h1F);
        send(2, 0, 8'h06, 0);
        for (int k = 0; k < 5; k++) send(2, 0, 8'(8'h16 + (k << 4)), 0);
        drain("c");
        chk("stats_sat_c", stats_c[0], EXP_STATS_C);

        // Reset in the middle of traffic.
        out_ready[0] = 5'b0;
        in_data[0][0] = 8'h07;
        in_data[0][1] = 8'h09;
        in_valid[0] = 5'b00011;
        step();
        step();
        step();
        in_valid[0] = 5'b0;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid[0], 0);
        chk("mid_rst_data", out_data[0], 0);
        chk("mid_rst_inready", in_ready[0], 5'h1F);
        chk("mid_rst_stats", stats_a, 0);
        for (int q = 0; q < 15; q++) exp_q[q].delete();
        step();
        arst_n = 1'b1;
        out_ready[0] = 5'h1F;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid[0] != 5'b0) cnt++;
            step();
        end
        chk("mid_rst_flushed", cnt, 0);

        // Statistics: three S deliveries after reset.
        for (int k = 0; k < 3; k++) send(0, 0, 8'(8'h09 + (k << 4)), 2);
        drain("stats");
        chk("stats_s", stats_a[2], EXP_STATS_A);
        chk("stats_e", stats_a[3], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
